cachemem_rd_dm: RTL and testbench
=================================

Name: cachemem_rd_dm

Overview:
- Parametrised direct-mapped, read-only cache for the RV32I core fetch/load path.
- Holds NUM_LINES lines of LINE_WORDS 32-bit words, each with its own tag and valid bit. This replaces the single-page 4KB reader.
- On a miss, fetches exactly one line over an AXI4 INCR burst. Hits return data one cycle after the request.
- Supports single-cycle whole-cache invalidation (for FENCE.I) and reports AXI read errors.

Parameters:
- LINE_WORDS, 32, words per line; power of 2, 2..256; ARLEN = LINE_WORDS-1.
- NUM_LINES, 32, number of lines; power of 2, 1..1024. Capacity = 4*LINE_WORDS*NUM_LINES bytes.
- C_M_AXI_THREAD_ID_WIDTH, 1, ARID/RID width.
- C_M_AXI_ADDR_WIDTH, 32, ARADDR width.
- C_M_AXI_DATA_WIDTH, 32, RDATA width; only 32 is supported.
- C_M_AXI_ARUSER_WIDTH, 1, ARUSER width.
- C_M_AXI_RUSER_WIDTH, 4, RUSER width.

Ports:
- CLK  in  1  clock.
- RSTN  in  1  reset; asynchronous, active-low.
- ADDR  in  32  byte address; bits [1:0] are ignored.
- RDEN  in  1  read request, valid this cycle.
- INVALIDATE  in  1  one-cycle pulse; clears all valid bits.
- OADDR  out  32  ADDR registered, 1-cycle delay.
- DOUT  out  32  read data, aligned with VALID.
- VALID  out  1  DOUT holds hit data for OADDR.
- LOADING  out  1  combinational; the request cannot be served this cycle.
- RD_ERR  out  1  one-cycle pulse when a line fill completes with a non-OKAY RRESP.
- M_AXI_AR*  out  per AXI4  ARID=0, ARLEN=LINE_WORDS-1, ARSIZE=3'b010, ARBURST=INCR, ARLOCK=0, ARCACHE=4'b0011, ARPROT=0, ARQOS=0, ARUSER=0. ARADDR and ARVALID are registered.
- M_AXI_ARREADY  in  1
- M_AXI_R*  in  per AXI4  RID, RDATA, RRESP, RLAST, RUSER, RVALID.
- M_AXI_RREADY  out  1  registered; high only in state S_R.

Behaviour:
- Address split: OFS = log2(LINE_WORDS)+2, IDX = log2(NUM_LINES).
  - word = ADDR[OFS-1:2]
  - index = ADDR[OFS+IDX-1:OFS]
  - tag = ADDR[31:OFS+IDX]
- Storage:
  - Data RAM is inferred, 1 read/write port, synchronous read.
  - Tags are stored in RAM or registers. Valid bits are flip-flops.
- Reset (RSTN=0, async):
  - State = S_IDLE; all valid bits = 0.
  - ARVALID=0, RREADY=0, ARADDR=0, VALID=0, OADDR=0, RD_ERR=0. DOUT is undefined.
- hit = RDEN && state==S_IDLE && valid[index] && tag[index]==tag.
- Outputs:
  - Every cycle: OADDR<=ADDR and VALID<=hit.
  - DOUT is the data RAM output for the word addressed in the previous cycle. Latency is 1.
  - LOADING = RDEN && !hit.
- States:
  - S_IDLE:
    - On RDEN && !hit && !INVALIDATE: latch index/tag, set ARADDR={ADDR[31:OFS],OFS'b0}, ARVALID=1, go to S_AR.
    - With RDEN && INVALIDATE together, the invalidate wins and the miss is re-evaluated next cycle.
  - S_AR: hold ARADDR and ARVALID stable until ARREADY. On ARREADY: ARVALID=0, RREADY=1, word counter=0, err=0, go to S_R.
  - S_R:
    - Each RVALID writes RDATA to data[index][counter], then counter+1.
    - err |= (RRESP!=0).
    - RDATA in the same beat as RLAST is written before the transition.
  - On RVALID&&RLAST:
    - Write the tag.
    - valid[index] = !err_final && !inval_seen.
    - RD_ERR pulses if err_final. RREADY=0. Go to S_IDLE.
    - The requester's retry then hits, or misses again if the line was dropped.
- Boundary conditions:
  - RLAST before LINE_WORDS beats: the line is marked invalid. The counter wraps modulo LINE_WORDS and never writes outside the line.
  - INVALIDATE during S_AR or S_R: all valid bits are cleared immediately and inval_seen is set. The in-flight line is not marked valid; the AXI burst always completes.
  - The data RAM port is shared. During a fill the port is owned by the write side; lookups are stalled (LOADING=1, VALID=0).
  - A miss to the same index replaces the line. The old valid bit is cleared on entry to S_AR.
  - Reset mid-burst: the block returns to S_IDLE at once. The interconnect is reset by the same RSTN.
  - RDEN=0: no state change, VALID=0.

Optional Feature:
- Macro CACHEMEM_RD_STATS_EN.
- Defined: adds output ports STAT_HIT[31:0] and STAT_MISS[31:0], reset to 0.
  - STAT_HIT increments on every hit.
  - STAT_MISS increments on every S_IDLE->S_AR transition.
  - Both saturate at 32'hFFFF_FFFF. INVALIDATE does not clear them.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Cold miss, defaults:
  - Stimulus: RDEN with ADDR=0x0000_1234.
  - Response: one AR with ARADDR=0x0000_1200, ARLEN=0x1F. After 32 beats (RDATA=beat*4), the retry gives VALID=1 next cycle with DOUT=0x34 and OADDR=0x1234.
- Hit streaming:
  - Stimulus: after the fill, ADDR 0x1200..0x127C on consecutive cycles.
  - Response: VALID=1 every cycle, DOUT = word offset * 4, no AR issued.
- Conflict eviction:
  - Stimulus: fill 0x1200, then read 0x2200 (same index, new tag).
  - Response: a new AR at 0x2200. A later read of 0x1200 misses again.
- Invalidate mid-burst:
  - Stimulus: INVALIDATE pulse at beat 10 of the fill.
  - Response: the burst completes, the line stays invalid, and the retry issues a second AR at the same address.
- Error response:
  - Stimulus: RRESP=2'b10 on beat 5.
  - Response: RD_ERR pulses on the RLAST cycle and the line stays invalid. With LINE_WORDS=8 and NUM_LINES=4 the same test expects ARLEN=7.
- Reset mid-operation:
  - Stimulus: assert RSTN=0 during S_R with ARREADY stalls beforehand.
  - Response: RREADY and ARVALID drop asynchronously, all lines are invalid, and the next read misses. With CACHEMEM_RD_STATS_EN defined, hit/miss counts match 32/1 after the streaming test.

Source files
------------

// File: rtl/cachemem_rd_dm.sv
// Direct-mapped read-only cache with AXI4 line fill and FENCE.I invalidate.
// Optional hit/miss counters: define CACHEMEM_RD_STATS_EN.
`timescale 1ns/1ps
module cachemem_rd_dm #(
  parameter int LINE_WORDS              = 32,
  parameter int NUM_LINES               = 32,
  parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
  parameter int C_M_AXI_ADDR_WIDTH      = 32,
  parameter int C_M_AXI_DATA_WIDTH      = 32,
  parameter int C_M_AXI_ARUSER_WIDTH    = 1,
  parameter int C_M_AXI_RUSER_WIDTH     = 4
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [31:0] ADDR,
  input  logic        RDEN,
  input  logic        INVALIDATE,
  output logic [31:0] OADDR,
  output logic [31:0] DOUT,
  output logic        VALID,
  output logic        LOADING,
  output logic        RD_ERR,
`ifdef CACHEMEM_RD_STATS_EN
  output logic [31:0] STAT_HIT,
  output logic [31:0] STAT_MISS,
`endif
  output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
  output logic [7:0]                         M_AXI_ARLEN,
  output logic [2:0]                         M_AXI_ARSIZE,
  output logic [1:0]                         M_AXI_ARBURST,
  output logic                               M_AXI_ARLOCK,
  output logic [3:0]                         M_AXI_ARCACHE,
  output logic [2:0]                         M_AXI_ARPROT,
  output logic [3:0]                         M_AXI_ARQOS,
  output logic [C_M_AXI_ARUSER_WIDTH-1:0]    M_AXI_ARUSER,
  output logic                               M_AXI_ARVALID,
  input  logic                               M_AXI_ARREADY,
  input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_RDATA,
  input  logic [1:0]                         M_AXI_RRESP,
  input  logic                               M_AXI_RLAST,
  input  logic [C_M_AXI_RUSER_WIDTH-1:0]     M_AXI_RUSER,
  input  logic                               M_AXI_RVALID,
  output logic                               M_AXI_RREADY
);

  localparam int WW    = $clog2(LINE_WORDS);
  localparam int OFS   = WW + 2;
  localparam int IDX   = $clog2(NUM_LINES);
  localparam int IW    = (IDX > 0) ? IDX : 1;
  localparam int TW    = 32 - OFS - IDX;
  localparam int DEPTH = NUM_LINES * LINE_WORDS;
  localparam int AW    = $clog2(DEPTH);
  localparam int LAST  = LINE_WORDS - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R
  } state_t;

  state_t state_q, state_d;

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TW-1:0]        tag_q [NUM_LINES];
  logic [31:0]          mem [DEPTH];

  logic          arvalid_q, arvalid_d;
  logic [31:0]   araddr_q, araddr_d;
  logic          rready_q, rready_d;
  logic [WW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          inval_q, inval_d;
  logic          ovf_q, ovf_d;
  logic [IW-1:0] fidx_q, fidx_d;
  logic [TW-1:0] ftag_q, ftag_d;
  logic [31:0]   oaddr_q, oaddr_d;
  logic          vout_q, vout_d;
  logic          rd_err_q, rd_err_d;
  logic [31:0]   dout_q;

  logic [WW-1:0] req_word;
  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;
  logic [AW-1:0] ram_addr;
  logic          hit;
  logic          ram_we;
  logic          tag_we;
  logic          miss_go;
  logic          line_ok;

  assign req_word = ADDR[OFS-1:2];
  assign req_tag  = ADDR[31:OFS+IDX];

  generate
    if (IDX > 0) begin : g_idx
      assign req_idx = ADDR[OFS+IDX-1:OFS];
    end else begin : g_one
      assign req_idx = 1'b0;
    end
  endgenerate

  assign hit = RDEN && (state_q == S_IDLE) &&
               valid_q[req_idx] &&
               (tag_q[req_idx] == req_tag);

  // One RAM port: the fill owns it outside S_IDLE.
  assign ram_addr = (state_q == S_R) ?
                    AW'({fidx_q, cnt_q}) :
                    AW'({req_idx, req_word});

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    rready_d  = rready_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    inval_d   = inval_q;
    ovf_d     = ovf_q;
    fidx_d    = fidx_q;
    ftag_d    = ftag_q;
    rd_err_d  = 1'b0;
    ram_we    = 1'b0;
    tag_we    = 1'b0;
    miss_go   = 1'b0;
    line_ok   = 1'b0;
    oaddr_d   = ADDR;
    vout_d    = hit;
    unique case (state_q)
      S_IDLE: begin
        if (RDEN && !hit && !INVALIDATE) begin
          fidx_d           = req_idx;
          ftag_d           = req_tag;
          araddr_d         = {ADDR[31:OFS], {OFS{1'b0}}};
          arvalid_d        = 1'b1;
          inval_d          = 1'b0;
          valid_d[req_idx] = 1'b0;
          miss_go          = 1'b1;
          state_d          = S_AR;
        end
      end
      S_AR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          cnt_d     = '0;
          err_d     = 1'b0;
          ovf_d     = 1'b0;
          state_d   = S_R;
        end
      end
      S_R: begin
        if (M_AXI_RVALID) begin
          ram_we = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          err_d  = err_q | (M_AXI_RRESP != 2'b00);
          if (!M_AXI_RLAST && cnt_q == WW'(LAST))
            ovf_d = 1'b1;
          if (M_AXI_RLAST) begin
            // A short or overlong burst never validates the line.
            line_ok = !err_d && !inval_q && !INVALIDATE &&
                      !ovf_q && (cnt_q == WW'(LAST));
            tag_we          = 1'b1;
            valid_d[fidx_q] = line_ok;
            rd_err_d        = err_d;
            rready_d        = 1'b0;
            state_d         = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (INVALIDATE) begin
      valid_d = '0;
      if (state_q != S_IDLE)
        inval_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= S_IDLE;
      valid_q   <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      rready_q  <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      inval_q   <= 1'b0;
      ovf_q     <= 1'b0;
      fidx_q    <= '0;
      ftag_q    <= '0;
      oaddr_q   <= '0;
      vout_q    <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      rready_q  <= rready_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      inval_q   <= inval_d;
      ovf_q     <= ovf_d;
      fidx_q    <= fidx_d;
      ftag_q    <= ftag_d;
      oaddr_q   <= oaddr_d;
      vout_q    <= vout_d;
      rd_err_q  <= rd_err_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (ram_we)
      mem[ram_addr] <= M_AXI_RDATA[31:0];
    dout_q <= mem[ram_addr];
  end

  always_ff @(posedge CLK) begin
    if (tag_we)
      tag_q[fidx_q] <= ftag_q;
  end

`ifdef CACHEMEM_RD_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit && hit_cnt_q != 32'hFFFF_FFFF)
      hit_cnt_d = hit_cnt_q + 32'd1;
    if (miss_go && miss_cnt_q != 32'hFFFF_FFFF)
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign STAT_HIT  = hit_cnt_q;
  assign STAT_MISS = miss_cnt_q;
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, M_AXI_RID, M_AXI_RUSER};

  assign OADDR   = oaddr_q;
  assign DOUT    = dout_q;
  assign VALID   = vout_q;
  assign LOADING = RDEN && !hit;
  assign RD_ERR  = rd_err_q;

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = C_M_AXI_ADDR_WIDTH'(araddr_q);
  assign M_AXI_ARLEN   = 8'(LINE_WORDS - 1);
  assign M_AXI_ARSIZE  = 3'b010;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'b0011;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = 4'b0000;
  assign M_AXI_ARUSER  = '0;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_cachemem_rd_dm.sv
// Scoreboard bench for cachemem_rd_dm with a behavioural AXI4 read slave.
// Checks hits, fills, eviction, invalidate, errors, short bursts, reset.
`timescale 1ns/1ps
module tb_cachemem_rd_dm;

  localparam int LW = 32;
  localparam int NL = 32;
  localparam int LB = LW * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ADDR = '0;
  logic        RDEN = 1'b0;
  logic        INVALIDATE;
  logic [31:0] OADDR, DOUT;
  logic        VALID, LOADING, RD_ERR;
`ifdef CACHEMEM_RD_STATS_EN
  logic [31:0] STAT_HIT, STAT_MISS;
`endif
  logic [0:0]  ARID;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARLOCK;
  logic [3:0]  ARCACHE;
  logic [2:0]  ARPROT;
  logic [3:0]  ARQOS;
  logic [0:0]  ARUSER;
  logic        ARVALID, ARREADY;
  logic [0:0]  RID = '0;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST, RVALID, RREADY;
  logic [3:0]  RUSER = '0;

  cachemem_rd_dm #(.LINE_WORDS(LW), .NUM_LINES(NL)) dut (
    .CLK(clk), .RSTN(rst_n), .ADDR(ADDR), .RDEN(RDEN),
    .INVALIDATE(INVALIDATE), .OADDR(OADDR), .DOUT(DOUT),
    .VALID(VALID), .LOADING(LOADING), .RD_ERR(RD_ERR),
`ifdef CACHEMEM_RD_STATS_EN
    .STAT_HIT(STAT_HIT), .STAT_MISS(STAT_MISS),
`endif
    .M_AXI_ARID(ARID), .M_AXI_ARADDR(ARADDR), .M_AXI_ARLEN(ARLEN),
    .M_AXI_ARSIZE(ARSIZE), .M_AXI_ARBURST(ARBURST),
    .M_AXI_ARLOCK(ARLOCK), .M_AXI_ARCACHE(ARCACHE),
    .M_AXI_ARPROT(ARPROT), .M_AXI_ARQOS(ARQOS),
    .M_AXI_ARUSER(ARUSER), .M_AXI_ARVALID(ARVALID),
    .M_AXI_ARREADY(ARREADY), .M_AXI_RID(RID), .M_AXI_RDATA(RDATA),
    .M_AXI_RRESP(RRESP), .M_AXI_RLAST(RLAST), .M_AXI_RUSER(RUSER),
    .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  int   n_checks = 0;
  int   n_err = 0;
  int   rderr_cnt = 0;
  exp_t exp_q[$];
  logic [31:0] ar_q[$];
  exp_t mon_e;

  int err_beat = -1;
  int inval_beat = -1;
  int early_last = LW;
  int ar_stall = 0;

  function automatic logic [31:0] line_of(logic [31:0] a);
    return a & ~32'(LB - 1);
  endfunction

  function automatic logic [31:0] data_of(logic [31:0] a);
    return (line_of(a) ^ 32'h1200) + (a & 32'(LB - 1) & ~32'd3);
  endfunction

  // Scoreboard: every VALID must match the oldest expected hit.
  always @(negedge clk) begin
    if (rst_n) begin
      if (RD_ERR) rderr_cnt++;
      if (VALID) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL spurious_valid: OADDR=%h DOUT=%h, required VALID=0",
                   OADDR, DOUT);
        end else begin
          mon_e = exp_q.pop_front();
          if (OADDR !== mon_e.a || DOUT !== mon_e.d) begin
            n_err++;
            $display("FAIL hit_data: OADDR=%h DOUT=%h, required %h %h",
                     OADDR, DOUT, mon_e.a, mon_e.d);
          end
        end
      end
    end
  end

  // AXI read slave; RDATA encodes line address and beat number.
  initial begin : slave
    logic        busy, pend_ar, pend_r, had_err;
    logic [31:0] base, pend_base, exp_a;
    int          beat, stall_cnt;
    busy = 0; pend_ar = 0; pend_r = 0; had_err = 0;
    base = '0; pend_base = '0; beat = 0; stall_cnt = 0;
    ARREADY = 0; RVALID = 0; RLAST = 0; RDATA = '0;
    RRESP = '0; INVALIDATE = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 0; pend_ar = 0; pend_r = 0; stall_cnt = 0;
        ARREADY = 0; RVALID = 0; RLAST = 0; INVALIDATE = 0;
        continue;
      end
      INVALIDATE = 0;
      if (pend_ar) begin
        busy = 1; beat = 0; had_err = 0; base = pend_base;
      end
      if (pend_r) begin
        if (RRESP != 2'b00) had_err = 1;
        if (RLAST) begin
          n_checks++;
          if (RD_ERR !== had_err) begin
            n_err++;
            $display("FAIL rd_err_pulse: RD_ERR=%b, required %b",
                     RD_ERR, had_err);
          end
          busy = 0; err_beat = -1; inval_beat = -1; early_last = LW;
        end
        beat++;
      end
      if (!busy && ARVALID) begin
        if (stall_cnt < ar_stall) begin
          stall_cnt++; ARREADY = 0;
        end else begin
          stall_cnt = 0; ARREADY = 1;
        end
      end else begin
        ARREADY = 0;
      end
      if (busy) begin
        RVALID = 1;
        RDATA = (base ^ 32'h1200) + 32'(beat * 4);
        RRESP = (beat == err_beat) ? 2'b10 : 2'b00;
        RLAST = (beat == early_last - 1);
        INVALIDATE = (beat == inval_beat);
      end else begin
        RVALID = 0; RLAST = 0; RRESP = '0;
      end
      pend_ar = ARVALID && ARREADY;
      pend_r = RVALID && RREADY;
      if (pend_ar) begin
        pend_base = ARADDR;
        n_checks++;
        if (ar_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_ar: ARADDR=%h, required no AR", ARADDR);
        end else begin
          exp_a = ar_q.pop_front();
          if (ARADDR !== exp_a || ARLEN !== 8'(LW - 1)) begin
            n_err++;
            $display("FAIL ar_fields: ARADDR=%h ARLEN=%h, required %h %h",
                     ARADDR, ARLEN, exp_a, 8'(LW - 1));
          end
        end
      end
    end
  end

  task automatic rd(input logic [31:0] a, input int n_ar);
    int budget;
    @(negedge clk);
    ADDR = a;
    RDEN = 1;
    for (int i = 0; i < n_ar; i++) ar_q.push_back(line_of(a));
    #1;
    n_checks++;
    if (LOADING !== (n_ar > 0)) begin
      n_err++;
      $display("FAIL loading_%h: LOADING=%b, required %b",
               a, LOADING, n_ar > 0);
    end
    budget = 0;
    while (LOADING === 1'b1 && budget < 400) begin
      @(negedge clk);
      #1;
      budget++;
    end
    n_checks++;
    if (budget >= 400) begin
      n_err++;
      $display("FAIL fill_timeout_%h: still LOADING, required hit", a);
    end else begin
      exp_q.push_back('{a, data_of(a)});
    end
    @(negedge clk);
    RDEN = 0;
    n_checks++;
    if (ar_q.size() != 0) begin
      n_err++;
      $display("FAIL ar_count_%h: %0d ARs missing, required 0",
               a, ar_q.size());
    end
    ar_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ARVALID !== 0 || RREADY !== 0 || VALID !== 0 ||
        OADDR !== 32'h0 || RD_ERR !== 0) begin
      n_err++;
      $display("FAIL reset_outputs: ARV=%b RR=%b V=%b OA=%h E=%b, required 0",
               ARVALID, RREADY, VALID, OADDR, RD_ERR);
    end
    n_checks++;
    if (ARLEN !== 8'(LW - 1) || ARSIZE !== 3'b010 || ARBURST !== 2'b01 ||
        ARCACHE !== 4'b0011 || ARID !== 0 || ARLOCK !== 0 ||
        ARPROT !== 0 || ARQOS !== 0 || ARUSER !== 0) begin
      n_err++;
      $display("FAIL ar_const: LEN=%h SIZE=%b BURST=%b CACHE=%b, required %h 010 01 0011",
               ARLEN, ARSIZE, ARBURST, ARCACHE, 8'(LW - 1));
    end
    rst_n = 1;
  endtask

  task automatic test_cold_miss();
    rd(32'h0000_1234, 1);
  endtask

  task automatic test_back_to_back();
`ifdef CACHEMEM_RD_STATS_EN
    logic [31:0] h0;
    h0 = STAT_HIT;
`endif
    for (int i = 0; i < LW; i++) begin
      @(negedge clk);
      ADDR = 32'h1200 + 32'(i * 4);
      RDEN = 1;
      #1;
      n_checks++;
      if (LOADING !== 1'b0) begin
        n_err++;
        $display("FAIL stream_loading_%0d: LOADING=%b, required 0", i, LOADING);
      end
      exp_q.push_back('{ADDR, data_of(ADDR)});
    end
    @(negedge clk);
    RDEN = 0;
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL stream_drain: %0d hits outstanding, required 0",
               exp_q.size());
    end
`ifdef CACHEMEM_RD_STATS_EN
    n_checks++;
    if (STAT_HIT - h0 !== 32'(LW) || STAT_MISS !== 32'd1) begin
      n_err++;
      $display("FAIL stats: hits=%0d misses=%0d, required %0d 1",
               STAT_HIT - h0, STAT_MISS, LW);
    end
`endif
  endtask

  task automatic test_conflict();
    rd(32'h0000_2200, 1);
    rd(32'h0000_1200, 1);
    rd(32'h0000_1204, 0);
  endtask

  task automatic test_invalidate();
    inval_beat = 10;
    rd(32'h0000_3400, 2);
    rd(32'h0000_1200, 1);
  endtask

  task automatic test_error();
    rderr_cnt = 0;
    err_beat = 5;
    rd(32'h0000_4800, 2);
    n_checks++;
    if (rderr_cnt != 1) begin
      n_err++;
      $display("FAIL rd_err_count: %0d pulses, required 1", rderr_cnt);
    end
  endtask

  task automatic test_short_burst();
    early_last = 20;
    rd(32'h0000_5A00, 2);
  endtask

  task automatic test_reset_mid();
    int b;
    rd(32'h0000_7000, 1);
    rd(32'h0000_7008, 0);
    ar_stall = 3;
    @(negedge clk);
    ADDR = 32'h0000_6C00;
    RDEN = 1;
    ar_q.push_back(32'h0000_6C00);
    b = 0;
    while (RREADY !== 1'b1 && b < 100) begin
      @(negedge clk);
      b++;
    end
    n_checks++;
    if (b >= 100) begin
      n_err++;
      $display("FAIL reset_mid_wait: RREADY=%b, required 1", RREADY);
    end
    repeat (4) @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    n_checks++;
    if (ARVALID !== 0 || RREADY !== 0 || VALID !== 0 ||
        OADDR !== 32'h0 || RD_ERR !== 0) begin
      n_err++;
      $display("FAIL reset_async: ARV=%b RR=%b V=%b OA=%h E=%b, required 0",
               ARVALID, RREADY, VALID, OADDR, RD_ERR);
    end
    RDEN = 0;
    ar_q.delete();
    exp_q.delete();
    ar_stall = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    rd(32'h0000_7000, 1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_invalidate();
    test_error();
    test_short_burst();
    test_reset_mid();
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || ar_q.size() != 0) begin
      n_err++;
      $display("FAIL final_drain: exp=%0d ar=%0d, required 0 0",
               exp_q.size(), ar_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
